// File: rtl/css_mcu0_el2_pkg.sv
// Shared types and sizing for the IFU fetch buffer: entry layout and pointer/count widths.
package css_mcu0_el2_pkg;

    localparam int FB_DEPTH = 4;
    localparam int FB_DW    = 32;
    localparam int FB_PTR_W = $clog2(FB_DEPTH);
    localparam int FB_CNT_W = FB_PTR_W + 1;

    typedef struct packed {
        logic [31:1]      pc;
        logic [FB_DW-1:0] data;
        logic             fault;
    } fb_entry_t;

endpackage

// File: rtl/css_mcu0_el2_ifu_fetch_buf_if.sv
// Fetch-buffer bus: F-stage packet in, aligner consume in, two oldest entries and balancing out.
interface css_mcu0_el2_ifu_fetch_buf_if
    import css_mcu0_el2_pkg::*;
#(
    parameter int DW    = FB_DW,
    parameter int CNT_W = FB_CNT_W
);
    logic              ifc_fetch_req_f;
    logic              ic_hit_f;
    logic [31:1]       ifc_fetch_addr_f;
    logic [DW-1:0]     ic_data_f;
    logic              ic_access_fault_f;
    logic              exu_flush_final;
    logic              aln_consume1;
    logic              aln_consume2;
    logic              fb0_valid;
    logic              fb1_valid;
    logic [31:1]       fb0_pc;
    logic [31:1]       fb1_pc;
    logic [DW-1:0]     fb0_data;
    logic [DW-1:0]     fb1_data;
    logic              fb0_fault;
    logic              fb1_fault;
    logic              ifu_fb_consume1;
    logic              ifu_fb_consume2;
    logic [CNT_W-1:0]  fb_count;
    logic              fb_err;

    modport master (
        output ifc_fetch_req_f, ic_hit_f, ifc_fetch_addr_f, ic_data_f, ic_access_fault_f,
               exu_flush_final, aln_consume1, aln_consume2,
        input  fb0_valid, fb1_valid, fb0_pc, fb1_pc, fb0_data, fb1_data, fb0_fault, fb1_fault,
               ifu_fb_consume1, ifu_fb_consume2, fb_count, fb_err
    );

    modport slave (
        input  ifc_fetch_req_f, ic_hit_f, ifc_fetch_addr_f, ic_data_f, ic_access_fault_f,
               exu_flush_final, aln_consume1, aln_consume2,
        output fb0_valid, fb1_valid, fb0_pc, fb1_pc, fb0_data, fb1_data, fb0_fault, fb1_fault,
               ifu_fb_consume1, ifu_fb_consume2, fb_count, fb_err
    );

endinterface

// File: rtl/css_mcu0_el2_ifu_fb_ptr.sv
// Wrapping circular-buffer pointer: advance by 1 or 2, clear to 0; wraps naturally at 2**W.
module css_mcu0_el2_ifu_fb_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc1,
    input  logic         inc2,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc2) begin
            ptr_d = ptr_q + W'(2);
        end else if (inc1) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/css_mcu0_el2_ifu_fetch_buf.sv
// IFU fetch buffer: queues F-stage hit packets, shows the two oldest to the aligner.
// Optional CSS_MCU0_FB_BYPASS_EN forwards the incoming packet to fb0 when the buffer is empty.
module css_mcu0_el2_ifu_fetch_buf
    import css_mcu0_el2_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int DW    = FB_DW
) (
    input logic                           clk,
    input logic                           rst,
    css_mcu0_el2_ifu_fetch_buf_if.slave   fb_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fb_err_q;
    logic             fb_err_d;

    fb_entry_t        entry_q [DEPTH];
    fb_entry_t        wr_entry;
    fb_entry_t        ent0;
    fb_entry_t        ent1;
    logic [DW-1:0]    in_data;

    logic flush, wr_req, byp, stored0, stored1, full, fb0_vld;
    logic c1_eff, c2_eff, rd_inc1, overflow, wr_eff, err_evt;

    assign in_data  = fb_if.ic_data_f;
    assign wr_entry = '{pc: fb_if.ifc_fetch_addr_f, data: in_data, fault: fb_if.ic_access_fault_f};

    always_comb begin
        flush   = fb_if.exu_flush_final;
        wr_req  = fb_if.ifc_fetch_req_f & fb_if.ic_hit_f & ~flush;
        stored0 = (count_q > CNT_W'(0));
        stored1 = (count_q > CNT_W'(1));
        full    = (count_q == CNT_W'(DEPTH));
`ifdef CSS_MCU0_FB_BYPASS_EN
        byp     = wr_req & ~stored0;
`else
        byp     = 1'b0;
`endif
        fb0_vld = stored0 | byp;

        // Both consume strobes together are handled as consume2 (and flagged below).
        c2_eff  = fb_if.aln_consume2 & stored0 & stored1 & ~flush;
        c1_eff  = fb_if.aln_consume1 & ~fb_if.aln_consume2 & fb0_vld & ~flush;
        // A bypassed packet consumed in its arrival cycle never occupies a slot.
        rd_inc1 = c1_eff & stored0;

        overflow = wr_req & full & ~c1_eff & ~c2_eff;
        wr_eff   = wr_req & ~overflow & ~(byp & c1_eff);

        err_evt  = ~flush & (overflow
                           | (fb_if.aln_consume2 & ~stored1)
                           | (fb_if.aln_consume1 & ~fb_if.aln_consume2 & ~fb0_vld)
                           | (fb_if.aln_consume1 & fb_if.aln_consume2));
        fb_err_d = fb_err_q | err_evt;

        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(wr_eff) - CNT_W'(rd_inc1) - (c2_eff ? CNT_W'(2) : CNT_W'(0));
        end
    end

    css_mcu0_el2_ifu_fb_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc1 (wr_eff),
        .inc2 (1'b0),
        .clr  (flush),
        .ptr  (wr_ptr)
    );

    css_mcu0_el2_ifu_fb_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc1 (rd_inc1),
        .inc2 (c2_eff),
        .clr  (flush),
        .ptr  (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            fb_err_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            fb_err_q <= fb_err_d;
        end
    end

    // Payload storage is intentionally not reset; validity comes from count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && wr_eff && (wr_ptr == PTR_W'(i))) begin
                entry_q[i] <= wr_entry;
            end
        end
    end

    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
    assign ent0      = entry_q[rd_ptr];
    assign ent1      = entry_q[rd_ptr_p1];

    assign fb_if.fb0_valid       = fb0_vld;
    assign fb_if.fb0_pc          = byp ? wr_entry.pc    : ent0.pc;
    assign fb_if.fb0_data        = byp ? wr_entry.data  : ent0.data;
    assign fb_if.fb0_fault       = byp ? wr_entry.fault : ent0.fault;
    assign fb_if.fb1_valid       = stored1;
    assign fb_if.fb1_pc          = ent1.pc;
    assign fb_if.fb1_data        = ent1.data;
    assign fb_if.fb1_fault       = ent1.fault;
    assign fb_if.ifu_fb_consume1 = c1_eff;
    assign fb_if.ifu_fb_consume2 = c2_eff;
    assign fb_if.fb_count        = count_q;
    assign fb_if.fb_err          = fb_err_q;

endmodule

// File: tb/tb_css_mcu0_el2_ifu_fetch_buf.sv
// Directed bench for the IFU fetch buffer: fill, full+consume, overflow, flush, wrap, bypass.
module tb_css_mcu0_el2_ifu_fetch_buf;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    css_mcu0_el2_ifu_fetch_buf_if fb_if ();

    css_mcu0_el2_ifu_fetch_buf dut (
        .clk   (clk),
        .rst   (rst),
        .fb_if (fb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hit, input logic [31:0] addr, input logic [31:0] data,
                         input logic flush, input logic c1, input logic c2);
        fb_if.ifc_fetch_req_f   = hit;
        fb_if.ic_hit_f          = hit;
        fb_if.ifc_fetch_addr_f  = addr[31:1];
        fb_if.ic_data_f         = data;
        fb_if.ic_access_fault_f = 1'b0;
        fb_if.exu_flush_final   = flush;
        fb_if.aln_consume1      = c1;
        fb_if.aln_consume2      = c2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_count", 64'(fb_if.fb_count), 64'd0);
        check_eq("rst_fb0_valid", 64'(fb_if.fb0_valid), 64'd0);
        check_eq("rst_fb1_valid", 64'(fb_if.fb1_valid), 64'd0);
        check_eq("rst_err", 64'(fb_if.fb_err), 64'd0);

        // Fill with four hits
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 + 32'(4 * i);
            drive(1'b1, a, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
            check_eq($sformatf("fill%0d_count", i), 64'(fb_if.fb_count), 64'(i + 1));
        end
        idle();
        check_eq("fill_fb0_pc", 64'(fb_if.fb0_pc), 64'h800);
        check_eq("fill_fb1_pc", 64'(fb_if.fb1_pc), 64'h802);
        check_eq("fill_fb0_data", 64'(fb_if.fb0_data), 64'hA000_0000);
        check_eq("fill_fb1_valid", 64'(fb_if.fb1_valid), 64'd1);

        // Full: write plus consume2 in the same cycle
        drive(1'b1, 32'h1010, 32'hA000_0004, 1'b0, 1'b0, 1'b1);
        check_eq("full_c2_consume2", 64'(fb_if.ifu_fb_consume2), 64'd1);
        check_eq("full_c2_consume1", 64'(fb_if.ifu_fb_consume1), 64'd0);
        tick();
        idle();
        check_eq("full_c2_count", 64'(fb_if.fb_count), 64'd3);
        check_eq("full_c2_fb0_pc", 64'(fb_if.fb0_pc), 64'h804);
        check_eq("full_c2_err", 64'(fb_if.fb_err), 64'd0);

        // Refill to 4, then overflow
        drive(1'b1, 32'h1014, 32'hA000_0005, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("refill_count", 64'(fb_if.fb_count), 64'd4);
        drive(1'b1, 32'h1018, 32'hA000_0006, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check_eq("ovf_count", 64'(fb_if.fb_count), 64'd4);
        check_eq("ovf_err", 64'(fb_if.fb_err), 64'd1);
        check_eq("ovf_fb0_pc", 64'(fb_if.fb0_pc), 64'h804);
        check_eq("ovf_fb1_pc", 64'(fb_if.fb1_pc), 64'h806);
        tick();
        tick();
        check_eq("ovf_err_sticky", 64'(fb_if.fb_err), 64'd1);

        // Consume one to reach 3, then flush with hit+consume1
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("pre_flush_count", 64'(fb_if.fb_count), 64'd3);
        check_eq("pre_flush_fb0_pc", 64'(fb_if.fb0_pc), 64'h806);
        drive(1'b1, 32'h1020, 32'hA000_0007, 1'b1, 1'b1, 1'b0);
        check_eq("flush_consume1", 64'(fb_if.ifu_fb_consume1), 64'd0);
        tick();
        idle();
        check_eq("flush_count", 64'(fb_if.fb_count), 64'd0);
        check_eq("flush_fb0_valid", 64'(fb_if.fb0_valid), 64'd0);
        check_eq("flush_err_kept", 64'(fb_if.fb_err), 64'd1);

        // Reset clears the sticky error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst2_err", 64'(fb_if.fb_err), 64'd0);
        check_eq("rst2_count", 64'(fb_if.fb_count), 64'd0);

        // Wrap: prime one entry, then 9 write+consume1 pairs
        drive(1'b1, 32'h3000, 32'hB000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            a = 32'h3000 + 32'(4 * k);
            drive(1'b1, a, 32'hB000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
            check_eq($sformatf("wrap%0d_consume1", k), 64'(fb_if.ifu_fb_consume1), 64'd1);
            tick();
            check_eq($sformatf("wrap%0d_count", k), 64'(fb_if.fb_count), 64'd1);
            check_eq($sformatf("wrap%0d_fb0_pc", k), 64'(fb_if.fb0_pc), 64'(a[31:1]));
            check_eq($sformatf("wrap%0d_fb0_data", k), 64'(fb_if.fb0_data), 64'(32'hB000_0000 + 32'(k)));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        check_eq("wrap_drain_count", 64'(fb_if.fb_count), 64'd0);
        check_eq("wrap_err", 64'(fb_if.fb_err), 64'd0);

        // Empty buffer: hit 0x2000 with consume1 in the same cycle
        drive(1'b1, 32'h2000, 32'hC000_0000, 1'b0, 1'b1, 1'b0);
`ifdef CSS_MCU0_FB_BYPASS_EN
        check_eq("byp_fb0_valid", 64'(fb_if.fb0_valid), 64'd1);
        check_eq("byp_fb0_pc", 64'(fb_if.fb0_pc), 64'h1000);
        check_eq("byp_consume1", 64'(fb_if.ifu_fb_consume1), 64'd1);
        tick();
        idle();
        check_eq("byp_count", 64'(fb_if.fb_count), 64'd0);
        check_eq("byp_next_fb0_valid", 64'(fb_if.fb0_valid), 64'd0);
        check_eq("byp_err", 64'(fb_if.fb_err), 64'd0);
`else
        check_eq("nobyp_fb0_valid", 64'(fb_if.fb0_valid), 64'd0);
        check_eq("nobyp_consume1", 64'(fb_if.ifu_fb_consume1), 64'd0);
        tick();
        idle();
        check_eq("nobyp_count", 64'(fb_if.fb_count), 64'd1);
        check_eq("nobyp_next_fb0_valid", 64'(fb_if.fb0_valid), 64'd1);
        check_eq("nobyp_next_fb0_pc", 64'(fb_if.fb0_pc), 64'h1000);
        check_eq("nobyp_err", 64'(fb_if.fb_err), 64'd1);
`endif

        // consume2 with only one entry: no move, error flagged
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h4000, 32'hD000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("c2one_consume2", 64'(fb_if.ifu_fb_consume2), 64'd0);
        tick();
        idle();
        check_eq("c2one_count", 64'(fb_if.fb_count), 64'd1);
        check_eq("c2one_fb0_pc", 64'(fb_if.fb0_pc), 64'h2000);
        check_eq("c2one_err", 64'(fb_if.fb_err), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
